// File: rtl/oric_scan_doubler.sv
// Scan doubler for the Oric ULA: captures each 15.6 kHz line at 6 MHz into one bank
// of a two-bank line buffer and replays the other bank twice at 12 MHz.
module oric_scan_doubler #(
    parameter int HS_WIDTH  = 24,
    parameter int VS_DETECT = 96,
    parameter int LINE_CLKS = 768
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic SYNC,
    input  logic RED,
    input  logic GREEN,
    input  logic BLUE,
    output logic VGA_R,
    output logic VGA_G,
    output logic VGA_B,
    output logic VGA_HS,
    output logic VGA_VS,
    output logic LOCKED
);

    localparam int HALF = LINE_CLKS / 2;
    localparam int XW   = $clog2(LINE_CLKS);
    localparam int AW   = $clog2(HALF);
    localparam int CW   = $clog2(VS_DETECT + 1);

    localparam logic [XW-1:0] HALF_X = XW'(HALF);
    localparam logic [XW-1:0] LAST_X = XW'(LINE_CLKS - 1);
    localparam logic [XW-1:0] HS_X   = XW'(HS_WIDTH);
    localparam logic [CW-1:0] VS_MAX = CW'(VS_DETECT);

    logic          s1_reg;
    logic          s2_reg;
    logic [2:0]    rgb1_reg;
    logic [XW-1:0] in_x_reg;
    logic          in_bank_reg;
    logic [CW-1:0] low_cnt_reg;
    logic [2:0]    rgb_out_reg;
    logic          hs_reg;
    logic          vs_reg;
    logic          locked_reg;

    logic          fall;
    logic          wrap;
    logic          blank;
    logic [XW-1:0] out_x;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    logic [2:0] line_buf [0:1][0:HALF-1];

    assign fall    = s2_reg & ~s1_reg;
    assign wrap    = (in_x_reg == LAST_X);
    assign out_x   = (in_x_reg < HALF_X) ? in_x_reg : (in_x_reg - HALF_X);
    assign blank   = (out_x < HS_X);
    assign wr_addr = AW'(in_x_reg >> 1);
    assign rd_addr = AW'(out_x);

    // Capture on odd clocks only: the ULA pixel rate is half the clock rate.
    always_ff @(posedge CLK) begin
        if (in_x_reg[0]) begin
            line_buf[in_bank_reg][wr_addr] <= rgb1_reg;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            s1_reg      <= 1'b1;
            s2_reg      <= 1'b1;
            rgb1_reg    <= 3'b000;
            in_x_reg    <= '0;
            in_bank_reg <= 1'b0;
            low_cnt_reg <= '0;
            rgb_out_reg <= 3'b000;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            locked_reg  <= 1'b0;
        end else begin
            s1_reg   <= SYNC;
            s2_reg   <= s1_reg;
            rgb1_reg <= {RED, GREEN, BLUE};

            // A coincident wrap and fall is a single line start.
            if (fall || wrap) begin
                in_x_reg    <= '0;
                in_bank_reg <= ~in_bank_reg;
            end else begin
                in_x_reg <= in_x_reg + XW'(1);
            end

            if (s1_reg) begin
                low_cnt_reg <= '0;
            end else if (low_cnt_reg != VS_MAX) begin
                low_cnt_reg <= low_cnt_reg + CW'(1);
            end

            if (fall) begin
                locked_reg <= wrap;
            end

            hs_reg      <= ~blank;
            rgb_out_reg <= blank ? 3'b000 : line_buf[~in_bank_reg][rd_addr];
            // Gating with s1 releases vsync as soon as SYNC goes high again.
            vs_reg      <= ~((low_cnt_reg == VS_MAX) && !s1_reg);
        end
    end

    assign VGA_R  = rgb_out_reg[2];
    assign VGA_G  = rgb_out_reg[1];
    assign VGA_B  = rgb_out_reg[0];
    assign VGA_HS = hs_reg;
    assign VGA_VS = vs_reg;
    assign LOCKED = locked_reg;

endmodule

// File: tb/tb_oric_scan_doubler.sv
// Self-checking bench for oric_scan_doubler: pixel scoreboard, vsync vector table and
// hand-written sequences for lock, misaligned edge and mid-line reset.
module tb_oric_scan_doubler;

    localparam int HS_WIDTH  = 24;
    localparam int VS_DETECT = 96;
    localparam int LINE_CLKS = 768;

    logic CLK    = 1'b0;
    logic nRESET = 1'b1;
    logic SYNC, RED, GREEN, BLUE;
    logic VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, LOCKED;

    oric_scan_doubler #(
        .HS_WIDTH (HS_WIDTH),
        .VS_DETECT(VS_DETECT),
        .LINE_CLKS(LINE_CLKS)
    ) dut (
        .CLK   (CLK),
        .nRESET(nRESET),
        .SYNC  (SYNC),
        .RED   (RED),
        .GREEN (GREEN),
        .BLUE  (BLUE),
        .VGA_R (VGA_R),
        .VGA_G (VGA_G),
        .VGA_B (VGA_B),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .LOCKED(LOCKED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [2:0] rgb;
    } exp_t;

    typedef struct {
        int low_len;
        int line_len;
        int exp_vs_low;
        int exp_vs_delay;
        int exp_hs_falls;
    } vrow_t;

    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;
    exp_t       sb[$];
    int         pix_k[$];
    logic [2:0] pix_c[$];
    bit         mon_en = 1'b0;
    int         vs_low_cnt  = 0;
    int         hs_fall_cnt = 0;
    int         vs_fall_cyc = -1;
    logic       hs_prev = 1'b1;
    logic       vs_prev = 1'b1;
    logic [2:0] mon_rgb;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Output monitor, 1 time unit after each rising edge; cyc numbers the edges.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (VGA_VS === 1'b0) vs_low_cnt++;
        if (vs_prev === 1'b1 && VGA_VS === 1'b0) vs_fall_cyc = cyc;
        if (hs_prev === 1'b1 && VGA_HS === 1'b0) hs_fall_cnt++;
        hs_prev = VGA_HS;
        vs_prev = VGA_VS;
        if (mon_en) begin
            mon_rgb = {VGA_R, VGA_G, VGA_B};
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk($sformatf("pixel_at_%0d", cyc), int'(mon_rgb), int'(sb[0].rgb));
                void'(sb.pop_front());
            end else if (mon_rgb != 3'b000) begin
                chk($sformatf("stray_pixel_at_%0d", cyc), int'(mon_rgb), 0);
            end
        end
    end

    task automatic sb_insert(input int c, input logic [2:0] v);
        exp_t e;
        int   i = 0;
        e.cyc = c;
        e.rgb = v;
        while (i < sb.size() && sb[i].cyc < c) i++;
        sb.insert(i, e);
    endtask

    // One input line starting at the current falling clock edge. A pixel for index k is
    // driven at offset 2k+2 (registered, then written at in_x=2k+1); it is replayed at
    // out_x=k of the next line, i.e. LINE_CLKS+1-k edges after it is driven, then again
    // LINE_CLKS/2 edges later.
    task automatic drive_line(input int len, input int low_len);
        logic [2:0] c;
        for (int t = 0; t < len; t++) begin
            SYNC = (t < low_len) ? 1'b0 : 1'b1;
            c = 3'b000;
            for (int i = 0; i < pix_k.size(); i++) begin
                if (2 * pix_k[i] + 2 == t) begin
                    c = pix_c[i];
                    if (pix_k[i] >= HS_WIDTH) begin
                        sb_insert(cyc + LINE_CLKS + 1 - pix_k[i], c);
                        sb_insert(cyc + LINE_CLKS + 1 - pix_k[i] + LINE_CLKS / 2, c);
                    end
                end
            end
            {RED, GREEN, BLUE} = c;
            @(negedge CLK);
        end
        pix_k.delete();
        pix_c.delete();
    endtask

    task automatic measure_hs(input string tag);
        int k = 0;
        int w = 0;
        int h = 0;
        while (VGA_HS !== 1'b0 && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        chk({tag, "_hs_seen"}, int'(VGA_HS), 0);
        while (VGA_HS === 1'b0 && w < 1000) begin
            @(negedge CLK);
            w++;
        end
        while (VGA_HS === 1'b1 && h < 1000) begin
            @(negedge CLK);
            h++;
        end
        chk({tag, "_hs_width"}, w, HS_WIDTH);
        chk({tag, "_hs_period"}, w + h, LINE_CLKS / 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_r"}, int'(VGA_R), 0);
        chk({tag, "_g"}, int'(VGA_G), 0);
        chk({tag, "_b"}, int'(VGA_B), 0);
        chk({tag, "_hs"}, int'(VGA_HS), 1);
        chk({tag, "_vs"}, int'(VGA_VS), 1);
        chk({tag, "_locked"}, int'(LOCKED), 0);
    endtask

    vrow_t rows[5];

    initial begin
        int n, vs0, hs0, f0;
        SYNC = 1'b1;
        {RED, GREEN, BLUE} = 3'b000;
        #2 nRESET = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        nRESET = 1'b1;
        measure_hs("flywheel");
        repeat (500) @(negedge CLK);

        // First edge lands at an arbitrary phase, the second one a line later.
        drive_line(LINE_CLKS, 48);
        chk("locked_first_edge", int'(LOCKED), 0);
        drive_line(LINE_CLKS, 48);
        chk("locked_second_edge", int'(LOCKED), 1);

        // Every steady edge coincides with a wrap, so a double bank toggle would
        // replay the wrong line and miss these pixels.
        mon_en = 1'b1;
        pix_k = '{23, 24, 10, 100, 200, 382};
        pix_c = '{3'b111, 3'b111, 3'b100, 3'b100, 3'b010, 3'b001};
        drive_line(LINE_CLKS, 48);
        drive_line(LINE_CLKS, 48);
        drive_line(LINE_CLKS, 48);
        chk("scoreboard_drained", sb.size(), 0);
        chk("locked_steady", int'(LOCKED), 1);

        rows[0] = '{48,   768,  0,    0,  2};
        rows[1] = '{96,   768,  0,    0,  2};
        rows[2] = '{97,   768,  1,    98, 2};
        rows[3] = '{100,  768,  4,    98, 2};
        rows[4] = '{3072, 3840, 2976, 98, 10};
        for (int r = 0; r < 5; r++) begin
            n   = cyc;
            vs0 = vs_low_cnt;
            hs0 = hs_fall_cnt;
            f0  = vs_fall_cyc;
            drive_line(rows[r].line_len, rows[r].low_len);
            chk($sformatf("row%0d_vs_low_clks", r), vs_low_cnt - vs0, rows[r].exp_vs_low);
            chk($sformatf("row%0d_vs_delay", r), (vs_fall_cyc == f0) ? 0 : vs_fall_cyc - n,
                rows[r].exp_vs_delay);
            chk($sformatf("row%0d_hs_pulses", r), hs_fall_cnt - hs0, rows[r].exp_hs_falls);
            chk($sformatf("row%0d_locked", r), int'(LOCKED), 1);
        end

        // Fall injected so that it is detected at in_x=500.
        drive_line(501, 48);
        SYNC = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("misalign_locked_clear", int'(LOCKED), 0);
        chk("misalign_hs_before", int'(VGA_HS), 1);
        @(negedge CLK);
        chk("misalign_hs_restart", int'(VGA_HS), 0);
        drive_line(LINE_CLKS - 3, 45);
        chk("misalign_locked_hold", int'(LOCKED), 0);
        drive_line(LINE_CLKS, 48);
        chk("misalign_relock", int'(LOCKED), 1);

        // Reset in the middle of the second hsync pulse of a line.
        mon_en = 1'b0;
        drive_line(395, 48);
        chk("pre_reset_hs_low", int'(VGA_HS), 0);
        nRESET = 1'b0;
        #1;
        check_reset_outputs("midline_reset");
        @(negedge CLK);
        @(negedge CLK);
        nRESET = 1'b1;
        measure_hs("post_reset");
        chk("post_reset_locked", int'(LOCKED), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
